// File: rtl/fetch_stage.sv
// fetch_stage: PC/nPC delayed-branch fetch with IF/ID register, stall and flush.
module fetch_stage #(
    parameter int                ADDR_W    = 9,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0100_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              le,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [31:0]       rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              fetch_misalign
);
    logic [ADDR_W-1:0] pc, npc, npc_next;
    assign rom_addr = pc;
    // Branch targets are force-aligned to a word boundary; the raw low bits only feed the misalign flag.
    assign npc_next = branch_taken ? {branch_target[ADDR_W-1:2], 2'b00} : npc + ADDR_W'(4);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc             <= RESET_PC;
            npc            <= RESET_PC + ADDR_W'(4);
            if_id_instr    <= NOP_INSTR;
            if_id_pc       <= '0;
            if_id_valid    <= 1'b0;
            fetch_misalign <= 1'b0;
        end else begin
            if (le) begin
                pc             <= npc;
                npc            <= npc_next;
                fetch_misalign <= branch_taken & |branch_target[1:0];
            end
            if (flush) begin
                if_id_instr <= NOP_INSTR;
                if_id_pc    <= pc;
                if_id_valid <= 1'b0;
            end else if (le) begin
                if_id_instr <= rom_data;
                if_id_pc    <= pc;
                if_id_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a PC/nPC reference model.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0100_0000;
    logic        clk = 0, reset = 0, le = 0, flush = 0, branch_taken = 0;
    logic [8:0]  branch_target = '0;
    logic [31:0] rom_data, if_id_instr;
    logic [8:0]  rom_addr, if_id_pc;
    logic        if_id_valid, fetch_misalign;
    logic [31:0] rom_mem [128];
    logic [31:0] w [4];
    int tests = 0, fails = 0;
    bit chk_on = 0;
    int m_pc, m_npc, m_ifpc;
    logic [31:0] m_instr;
    bit m_valid, m_mis;

    fetch_stage dut (
        .clk(clk), .reset(reset), .le(le), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .rom_data(rom_data), .rom_addr(rom_addr), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;
    assign rom_data = rom_mem[rom_addr[8:2]];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got %0h want %0h", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on && reset === 1'b0) begin
            chk("model_rom_addr", 32'(rom_addr), 32'(m_pc));
            chk("model_instr", if_id_instr, m_instr);
            chk("model_if_pc", 32'(if_id_pc), 32'(m_ifpc));
            chk("model_valid", 32'(if_id_valid), 32'(m_valid));
            chk("model_misalign", 32'(fetch_misalign), 32'(m_mis));
        end
    end

    task automatic model_reset();
        m_pc = 0; m_npc = 4; m_instr = NOP; m_ifpc = 0; m_valid = 0; m_mis = 0;
    endtask

    task automatic cyc(input bit l, input bit f, input bit b, input int t);
        int nxt;
        le = l; flush = f; branch_taken = b;
        branch_target = b ? 9'(t) : 9'bx;
        @(posedge clk);
        if (f) begin
            m_instr = NOP; m_valid = 0; m_ifpc = m_pc;
        end else if (l) begin
            m_instr = rom_mem[m_pc / 4]; m_valid = 1; m_ifpc = m_pc;
        end
        if (l) begin
            m_mis = b && (t % 4 != 0);
            nxt = b ? (t / 4) * 4 : (m_npc + 4) % 512;
            m_pc = m_npc;
            m_npc = nxt;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1;
        model_reset();
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        w[0] = 32'hDEAD_0000; w[1] = 32'hBEEF_0004; w[2] = 32'hCAFE_0008; w[3] = 32'h1234_000C;
        for (int i = 0; i < 128; i++) rom_mem[i] = $urandom;
        for (int i = 0; i < 4; i++) rom_mem[i] = w[i];
        model_reset();
        #1 reset = 1;
        #2;
        chk("rst_rom_addr", 32'(rom_addr), 0);
        chk("rst_instr", if_id_instr, NOP);
        chk("rst_valid", 32'(if_id_valid), 0);
        chk("rst_if_pc", 32'(if_id_pc), 0);
        chk("rst_misalign", 32'(fetch_misalign), 0);
        @(negedge clk);
        reset = 0;
        chk_on = 1;
        // sequential fetch of W0..W3
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0);
            chk("seq_if_pc", 32'(if_id_pc), 32'(i * 4));
            chk("seq_instr", if_id_instr, w[i]);
            chk("seq_valid", 32'(if_id_valid), 1);
        end
        // stall at PC=8
        do_reset();
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 100);
            chk("stall_rom_addr", 32'(rom_addr), 8);
            chk("stall_if_pc", 32'(if_id_pc), 4);
            chk("stall_instr", if_id_instr, w[1]);
        end
        cyc(1, 0, 0, 0);
        chk("unstall_if_pc", 32'(if_id_pc), 8);
        chk("unstall_rom_addr", 32'(rom_addr), 12);
        // delayed branch from PC=4 to 40
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 40);
        chk("br_if_pc0", 32'(if_id_pc), 4);
        cyc(1, 0, 0, 0);
        chk("br_if_pc1", 32'(if_id_pc), 8);
        cyc(1, 0, 0, 0);
        chk("br_if_pc2", 32'(if_id_pc), 40);
        cyc(1, 0, 0, 0);
        chk("br_if_pc3", 32'(if_id_pc), 44);
        // flush with and without le
        do_reset();
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("flush_instr", if_id_instr, NOP);
        chk("flush_valid", 32'(if_id_valid), 0);
        chk("flush_rom_addr", 32'(rom_addr), 16);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("flush_stall_instr", if_id_instr, NOP);
        chk("flush_stall_valid", 32'(if_id_valid), 0);
        chk("flush_stall_rom_addr", 32'(rom_addr), 20);
        // wrap 504 -> 508 -> 0, then misaligned target
        do_reset();
        cyc(1, 0, 1, 504);
        cyc(1, 0, 0, 0);
        chk("wrap_pc0", 32'(rom_addr), 504);
        cyc(1, 0, 0, 0);
        chk("wrap_pc1", 32'(rom_addr), 508);
        cyc(1, 0, 0, 0);
        chk("wrap_pc2", 32'(rom_addr), 0);
        cyc(1, 0, 1, 'h2B);
        chk("mis_set", 32'(fetch_misalign), 1);
        cyc(1, 0, 0, 0);
        chk("mis_target_aligned", 32'(rom_addr), 'h28);
        chk("mis_clear", 32'(fetch_misalign), 0);
        // asynchronous reset during a stall
        cyc(0, 0, 0, 0);
        #2 reset = 1;
        #1;
        chk("areset_rom_addr", 32'(rom_addr), 0);
        chk("areset_valid", 32'(if_id_valid), 0);
        chk("areset_instr", if_id_instr, NOP);
        chk("areset_if_pc", 32'(if_id_pc), 0);
        model_reset();
        @(negedge clk);
        reset = 0;
        // random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 6) == 0, int'($urandom_range(0, 511)));
        end
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the 512-byte instruction ROM (`rom`, 9-bit byte address A, 32-bit word I, combinational read). It holds the PC/nPC pair and drives the ROM address. It also captures the returned word plus its PC into the IF/ID pipeline register. It supports stall (load enable), IF/ID flush and delayed-branch redirection (SPARC-style PC/nPC).

Parameters:
ADDR_W, 9, width of PC/nPC and ROM address (byte address, 2^ADDR_W bytes).
RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+4.
NOP_INSTR, 32'h0100_0000, word loaded into IF/ID on reset or flush.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
le  input  1  load enable; 0 = stall (PC, nPC, IF/ID hold).
flush  input  1  replace IF/ID contents with NOP_INSTR, valid=0.
branch_taken  input  1  redirect nPC to branch_target (delayed branch).
branch_target  input  ADDR_W  redirect byte address.
rom_data  input  32  instruction word I from ROM for rom_addr.
rom_addr  output  ADDR_W  address A to ROM; equals PC.
if_id_instr  output  32  registered instruction.
if_id_pc  output  ADDR_W  registered PC of if_id_instr.
if_id_valid  output  1  1 = if_id_instr is a real fetched instruction.
fetch_misalign  output  1  registered flag: last accepted branch_target had [1:0] != 0.

Behaviour:
- Reset (async, any time incl. mid-stall): PC=RESET_PC, nPC=RESET_PC+4, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0, fetch_misalign=0. The first rising edge after reset deassertion is a normal cycle.
- rom_addr = PC combinationally; ROM is zero-latency, so rom_data is valid in the same cycle.
- Rising edge, le=1, flush=0:
  - if_id_instr<=rom_data, if_id_pc<=PC, if_id_valid<=1.
  - PC<=nPC.
  - nPC<= branch_taken ? {branch_target[ADDR_W-1:2],2'b00} : nPC+4.
- Delayed branch: the instruction at old nPC (delay slot) is always fetched before the target. There is exactly one delay slot.
- le=0: PC, nPC, if_id_* and fetch_misalign hold. branch_taken is ignored while stalled; the producer holds it until a cycle with le=1.
- flush=1 (regardless of le): if_id_instr<=NOP_INSTR, if_id_valid<=0, if_id_pc<=PC.
  - PC/nPC still update per le/branch_taken. flush+le=1 advances the PC; the fetched word is discarded.
  - flush has priority over stall for the IF/ID register only.
- fetch_misalign: on le=1, it is set to (branch_taken & |branch_target[1:0]). Otherwise it holds. The target is still force-aligned.
- Arithmetic: nPC+4 is modulo 2^ADDR_W, so 508+4 wraps to 0 for ADDR_W=9. No overflow flag.
- branch_taken with target equal to current nPC+4 behaves identically to no branch.
- X on branch_target while branch_taken=0 must not propagate to state.

Test Plan:
- Reset then ROM preloaded with words W0..W3 at 0,4,8,12, le=1, 4 edges -> if_id_pc = 0,4,8,12 and if_id_instr = W0..W3 in order; valid goes 0→1 at the first edge.
- Stall: le=0 for 3 cycles after PC=8 -> rom_addr stays 8 and if_id_* unchanged. On le=1, if_id_pc=8 at the next edge.
- Delayed branch: with PC=4 (nPC=8) and branch_taken=1, target=40 at one le=1 edge -> subsequent if_id_pc = 4, 8, 40, 44.
- Flush: flush=1 with le=1 at PC=12 -> if_id_instr=32'h0100_0000, valid=0, PC=16. With flush=1 and le=0, IF/ID is NOPed and PC holds.
- Wrap and misalign: at PC=504, step 3 edges -> PC sequence 504,508,0. A branch to target=0x2B -> nPC=0x28 and fetch_misalign=1 for that cycle.
- Async reset asserted mid-cycle during stall -> outputs take reset values immediately, without waiting for clk.
